seq_shift_add_mult: RTL and testbench

//  Parametrised iterative shift-add multiplier. Processes one multiplier bit per clock.

---
 rtl/seq_shift_add_mult.sv | 107 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement operands, valid/ready handshakes on operand and result sides.
module seq_shift_add_mult #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 exit_now;
  logic                 last_bit;

  // -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic n);
    return n ? -v : v;
  endfunction

  assign addend   = mplr[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign acc_sum  = acc + addend;
  assign exit_now = EARLY_EXIT && (mplr == '0);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (exit_now || last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: operands latched on acceptance, result loaded on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= magnitude(a, is_signed);
            mplr  <= magnitude(b, is_signed);
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (exit_now) begin
            res <= apply_sign(acc, neg);
          end else begin
            acc  <= acc_sum;
            mplr <= mplr >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (last_bit) res <= apply_sign(acc_sum, neg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: three instances (W4, W8, W8 early-exit) checked
// every cycle against a transaction-level product/latency model.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv  = '0;
  logic [2:0]  orr = '0;
  logic [2:0]  sg  = '0;
  logic [7:0]  a_v [3];
  logic [7:0]  b_v [3];
  logic [2:0]  ov, ir, bz;
  logic [7:0]  res0;
  logic [15:0] res1, res2;

  int vectors     = 0;
  int miscompares = 0;

  // model state: 0 idle, 1 computing, 2 result presented
  int          m_phase [3];
  int          m_left  [3];
  logic [15:0] m_pend  [3];
  logic [15:0] m_res   [3];

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .is_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .res(res0), .busy(bz[0]));

  seq_shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_v[1]), .b(b_v[1]), .is_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .res(res1), .busy(bz[1]));

  seq_shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_v[2]), .b(b_v[2]), .is_signed(sg[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .res(res2), .busy(bz[2]));

  function automatic int wof(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic logic [15:0] res_of(int k);
    if (k == 0) return {8'h00, res0};
    if (k == 1) return res1;
    return res2;
  endfunction

  function automatic longint opval(int k, logic [7:0] v, logic s);
    int w = wof(k);
    longint x = longint'(v) & ((longint'(1) << w) - 1);
    if (s && v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic logic [15:0] ref_prod(int k, logic [7:0] av, logic [7:0] bv, logic s);
    int w = wof(k);
    longint p = opval(k, av, s) * opval(k, bv, s);
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  // Early exit: done once the highest set bit of |b| has been consumed
  function automatic int ref_lat(int k, logic [7:0] bv, logic s);
    int w = wof(k);
    int hi = 0;
    longint y = opval(k, bv, s);
    if (y < 0) y = -y;
    if (k != 2) return w;
    if (y == 0) return 1;
    for (int i = 0; i < w; i++) if (y[i]) hi = i;
    return (hi + 2 > w) ? w : hi + 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_phase[k] <= 0;
        m_left[k]  <= 0;
        m_pend[k]  <= '0;
        m_res[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        case (m_phase[k])
          0: if (iv[k]) begin
            m_phase[k] <= 1;
            m_left[k]  <= ref_lat(k, b_v[k], sg[k]);
            m_pend[k]  <= ref_prod(k, a_v[k], b_v[k], sg[k]);
          end
          1: begin
            m_left[k] <= m_left[k] - 1;
            if (m_left[k] == 1) begin
              m_phase[k] <= 2;
              m_res[k]   <= m_pend[k];
            end
          end
          default: if (orr[k]) m_phase[k] <= 0;
        endcase
      end
    end
  end

  task automatic compare_all();
    logic [18:0] exp_v, act_v;
    for (int k = 0; k < 3; k++) begin
      exp_v = {m_phase[k] == 2, m_phase[k] == 0, m_phase[k] != 0, m_res[k]};
      act_v = {ov[k], ir[k], bz[k], res_of(k)};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_check inst%0d t=%0t: {ov,ir,busy,res} got %h expected %h",
                 k, $time, act_v, exp_v);
      end
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic summary_and_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic start(int k, logic [7:0] av, logic [7:0] bv, logic s);
    @(negedge clk);
    a_v[k] = av; b_v[k] = bv; sg[k] = s; iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
  endtask

  task automatic wait_done(int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!ov[k] && lat < 40);
    if (!ov[k]) begin
      miscompares++;
      $display("FAIL timeout inst%0d: out_valid got 0 expected 1 within 40 cycles", k);
      summary_and_end();
    end
  endtask

  task automatic handoff(int k, int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    orr[k] = 1'b1;
    @(posedge clk);
    #1 orr[k] = 1'b0;
  endtask

  task automatic run_chk(string nm, int k, logic [7:0] av, logic [7:0] bv, logic s,
                         logic [15:0] exp_res, int exp_lat);
    int lat;
    start(k, av, bv, s);
    wait_done(k, lat);
    chk({nm, "_res"}, res_of(k), exp_res);
    chk({nm, "_lat"}, lat, exp_lat);
    handoff(k, 0);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic rs;
    int rk;
    for (int k = 0; k < 3; k++) begin a_v[k] = '0; b_v[k] = '0; end
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_res0", res0, 0);
    chk("reset_res1", res1, 0);
    chk("reset_out_valid", ov, 0);
    chk("reset_in_ready", ir, 3'b111);
    chk("reset_busy", bz, 0);

    // Directed products with hand-computed expectations
    run_chk("u15x15",   0, 8'd15,  8'd15,  1'b0, 16'd225,   4);
    run_chk("s8x7",     0, 8'h08,  8'h07,  1'b1, 16'h00C8,  4);
    run_chk("s8x8",     0, 8'h08,  8'h08,  1'b1, 16'h0040,  4);
    run_chk("sFx1",     0, 8'h0F,  8'h01,  1'b1, 16'h00FF,  4);
    run_chk("s0xF",     0, 8'h00,  8'h0F,  1'b1, 16'h0000,  4);
    run_chk("w8_s80x80",1, 8'h80,  8'h80,  1'b1, 16'h4000,  8);
    run_chk("w8_uFFxFF",1, 8'hFF,  8'hFF,  1'b0, 16'hFE01,  8);
    run_chk("w8_sFFx7F",1, 8'hFF,  8'h7F,  1'b1, 16'hFF81,  8);
    run_chk("ee_b1",    2, 8'd7,   8'd1,   1'b0, 16'd7,     2);
    run_chk("ee_b0",    2, 8'd99,  8'd0,   1'b0, 16'd0,     1);
    run_chk("ee_b80",   2, 8'd2,   8'h80,  1'b0, 16'd256,   8);
    run_chk("ee_sb80",  2, 8'd2,   8'h80,  1'b1, 16'hFF00,  8);
    run_chk("ee_b6",    2, 8'd10,  8'd6,   1'b0, 16'd60,    4);
    run_chk("ee_sbFE",  2, 8'd5,   8'hFE,  1'b1, 16'hFFF6,  3);

    // Backpressure: result held while in_valid pulses are ignored
    start(0, 8'd9, 8'd6, 1'b0);
    wait_done(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = (i % 2 == 0); a_v[0] = 8'd3; b_v[0] = 8'd3;
      @(posedge clk);
      #1;
      chk("bp_res", res0, 54);
      chk("bp_out_valid", ov[0], 1);
      chk("bp_in_ready", ir[0], 0);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    handoff(0, 0);
    chk("bp_after_valid", ov[0], 0);
    chk("bp_after_busy", bz[0], 0);
    chk("bp_after_res", res0, 54);

    // Asynchronous reset two cycles into an 8-cycle operation
    run_chk("pre_rst", 1, 8'd200, 8'd100, 1'b0, 16'd20000, 8);
    start(1, 8'd255, 8'd255, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_res", res1, 0);
    chk("arst_out_valid", ov[1], 0);
    chk("arst_busy", bz[1], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 chk("arst_no_result", ov[1], 0);
    end
    run_chk("post_rst", 1, 8'd3, 8'd5, 1'b0, 16'd15, 8);

    // Mixed random traffic with random consumer stalls
    for (int n = 0; n < 1000; n++) begin
      rk = n % 3;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n % 17 == 0) rb = 8'h00;
      if (n % 23 == 0) begin ra = 8'h80; rb = 8'h80; end
      rs = 1'($urandom_range(0, 1));
      start(rk, ra, rb, rs);
      wait_done(rk, lat);
      chk("rand_res", res_of(rk), ref_prod(rk, ra, rb, rs));
      chk("rand_lat", lat, ref_lat(rk, rb, rs));
      handoff(rk, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    summary_and_end();
  end

endmodule
